// File: rtl/agc_multi_stats.sv
// rtl/agc_multi_stats.sv - multi-channel AGC window statistics (sum of squares, gt/lt counts) with AXI-Stream readout
// Optional: AGC_MULTI_STATS_CONTINUOUS_EN restarts the window automatically after each dump.
module agc_multi_stats #(
    parameter int NCHAN     = 8,
    parameter int NSAMP     = 8,
    parameter int WLEN_BITS = 17,
    parameter int SQ_BITS   = 48,
    parameter int CNT_BITS  = 24
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NCHAN*NSAMP*12-1:0]     dat_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [WLEN_BITS-1:0]          wlen_i,
    input  logic [11:0]                   thresh_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [SQ_BITS+2*CNT_BITS-1:0] res_tdata,
    output logic [$clog2(NCHAN)-1:0]      res_tuser,
    output logic                          res_tlast,
    output logic                          res_tvalid,
    input  logic                          res_tready
);
    localparam int NS  = NCHAN * NSAMP;
    localparam int PCW = $clog2(NSAMP + 1);
    localparam int SSW = 23 + $clog2(NSAMP);
    localparam int AW  = ((SQ_BITS > SSW) ? SQ_BITS : SSW) + 1;
    localparam int CHW = $clog2(NCHAN);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DUMP} state_t;

    state_t               state_q;
    logic [WLEN_BITS:0]   wcnt_q;
    logic [1:0]           fcnt_q;
    logic [11:0]          thr_q;
`ifdef AGC_MULTI_STATS_CONTINUOUS_EN
    logic [WLEN_BITS-1:0] wlen_q;
`endif
    logic                 v1_q, v2_q;
    logic [NS*12-1:0]     s1_q;
    logic [22:0]          sq2_q [NS];
    logic [NS-1:0]        gt2_q, lt2_q;
    logic [SQ_BITS-1:0]   sq_acc_q [NCHAN];
    logic [CNT_BITS-1:0]  gt_q [NCHAN];
    logic [CNT_BITS-1:0]  lt_q [NCHAN];

    function automatic logic [WLEN_BITS:0] wcnt_init(input logic [WLEN_BITS-1:0] w);
        return (w == '0) ? {1'b1, {WLEN_BITS{1'b0}}} : {1'b0, w};
    endfunction

    // Stage 2 combinational: 23-bit signed arithmetic is exact for |x| <= 2048 squared.
    logic signed [22:0] xe [NS];
    logic [22:0]        sq_w [NS];
    logic [NS-1:0]      gt_w, lt_w;
    logic signed [22:0] pth, nth;

    always_comb begin
        pth = $signed({11'b0, thr_q});
        nth = -pth;
        for (int i = 0; i < NS; i++) begin
            xe[i]   = 23'($signed(s1_q[12*i +: 12]));
            sq_w[i] = xe[i] * xe[i];
            gt_w[i] = (xe[i] > pth);
            lt_w[i] = (xe[i] < nth);
        end
    end

    logic [SSW-1:0]      ssum [NCHAN];
    logic [PCW-1:0]      gsum [NCHAN];
    logic [PCW-1:0]      lsum [NCHAN];
    logic [AW-1:0]       sq_sum [NCHAN];
    logic [CNT_BITS:0]   gt_sum [NCHAN];
    logic [CNT_BITS:0]   lt_sum [NCHAN];

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            ssum[c] = '0;
            gsum[c] = '0;
            lsum[c] = '0;
            for (int s = 0; s < NSAMP; s++) begin
                ssum[c] = ssum[c] + SSW'(sq2_q[c*NSAMP+s]);
                gsum[c] = gsum[c] + PCW'(gt2_q[c*NSAMP+s]);
                lsum[c] = lsum[c] + PCW'(lt2_q[c*NSAMP+s]);
            end
            sq_sum[c] = AW'(sq_acc_q[c]) + AW'(ssum[c]);
            gt_sum[c] = (CNT_BITS+1)'(gt_q[c]) + (CNT_BITS+1)'(gsum[c]);
            lt_sum[c] = (CNT_BITS+1)'(lt_q[c]) + (CNT_BITS+1)'(lsum[c]);
        end
    end

    logic [CHW-1:0] ch_nx;
    assign ch_nx = res_tuser + CHW'(1);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s1_q  <= '0;
            gt2_q <= '0;
            lt2_q <= '0;
            for (int i = 0; i < NS; i++) sq2_q[i] <= '0;
        end else begin
            v1_q  <= (state_q == RUN) && !abort_i;
            v2_q  <= v1_q && !abort_i;
            s1_q  <= dat_i;
            gt2_q <= gt_w;
            lt2_q <= lt_w;
            for (int i = 0; i < NS; i++) sq2_q[i] <= sq_w[i];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            fcnt_q     <= '0;
            thr_q      <= '0;
`ifdef AGC_MULTI_STATS_CONTINUOUS_EN
            wlen_q     <= '0;
`endif
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            res_tdata  <= '0;
            res_tuser  <= '0;
            res_tlast  <= 1'b0;
            res_tvalid <= 1'b0;
            for (int c = 0; c < NCHAN; c++) begin
                sq_acc_q[c] <= '0;
                gt_q[c]     <= '0;
                lt_q[c]     <= '0;
            end
        end else begin
            done_o <= 1'b0;
            if (v2_q) begin
                for (int c = 0; c < NCHAN; c++) begin
                    sq_acc_q[c] <= (sq_sum[c][AW-1:SQ_BITS] != '0) ? '1 : sq_sum[c][SQ_BITS-1:0];
                    gt_q[c]     <= gt_sum[c][CNT_BITS] ? '1 : gt_sum[c][CNT_BITS-1:0];
                    lt_q[c]     <= lt_sum[c][CNT_BITS] ? '1 : lt_sum[c][CNT_BITS-1:0];
                end
            end
            if (abort_i) begin
                state_q    <= IDLE;
                busy_o     <= 1'b0;
                res_tvalid <= 1'b0;
                res_tlast  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        thr_q   <= thresh_i;
`ifdef AGC_MULTI_STATS_CONTINUOUS_EN
                        wlen_q  <= wlen_i;
`endif
                        wcnt_q  <= wcnt_init(wlen_i);
                        state_q <= RUN;
                        busy_o  <= 1'b1;
                        for (int c = 0; c < NCHAN; c++) begin
                            sq_acc_q[c] <= '0;
                            gt_q[c]     <= '0;
                            lt_q[c]     <= '0;
                        end
                    end
                    RUN: if (wcnt_q == (WLEN_BITS+1)'(1)) begin
                        state_q <= FLUSH;
                        fcnt_q  <= 2'd2;
                    end else begin
                        wcnt_q  <= wcnt_q - (WLEN_BITS+1)'(1);
                    end
                    FLUSH: if (fcnt_q == 2'd0) begin
                        state_q    <= DUMP;
                        res_tdata  <= {lt_q[0], gt_q[0], sq_acc_q[0]};
                        res_tuser  <= '0;
                        res_tlast  <= (NCHAN == 1);
                        res_tvalid <= 1'b1;
                    end else begin
                        fcnt_q     <= fcnt_q - 2'd1;
                    end
                    DUMP: if (res_tready) begin
                        if (res_tlast) begin
                            res_tvalid <= 1'b0;
                            res_tlast  <= 1'b0;
                            done_o     <= 1'b1;
`ifdef AGC_MULTI_STATS_CONTINUOUS_EN
                            state_q    <= RUN;
                            wcnt_q     <= wcnt_init(wlen_q);
                            for (int c = 0; c < NCHAN; c++) begin
                                sq_acc_q[c] <= '0;
                                gt_q[c]     <= '0;
                                lt_q[c]     <= '0;
                            end
`else
                            state_q    <= IDLE;
                            busy_o     <= 1'b0;
`endif
                        end else begin
                            res_tdata  <= {lt_q[ch_nx], gt_q[ch_nx], sq_acc_q[ch_nx]};
                            res_tuser  <= ch_nx;
                            res_tlast  <= (ch_nx == CHW'(NCHAN-1));
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_agc_multi_stats.sv
// tb/tb_agc_multi_stats.sv - directed table-driven bench for agc_multi_stats (8ch x 8 samples, 4-bit wlen, 24-bit sq, 8-bit counts)
module tb_agc_multi_stats;
    localparam int NCH = 8;
    localparam int NSM = 8;
`ifdef AGC_MULTI_STATS_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  aresetn;
    logic [NCH*NSM*12-1:0] dat_i;
    logic                  start_i, abort_i, res_tready;
    logic [3:0]            wlen_i;
    logic [11:0]           thresh_i;
    logic                  busy_o, done_o, res_tlast, res_tvalid;
    logic [39:0]           res_tdata;
    logic [2:0]            res_tuser;

    agc_multi_stats #(.NCHAN(NCH), .NSAMP(NSM), .WLEN_BITS(4), .SQ_BITS(24), .CNT_BITS(8)) dut (
        .aclk(clk), .aresetn(aresetn), .dat_i(dat_i), .start_i(start_i), .abort_i(abort_i),
        .wlen_i(wlen_i), .thresh_i(thresh_i), .busy_o(busy_o), .done_o(done_o),
        .res_tdata(res_tdata), .res_tuser(res_tuser), .res_tlast(res_tlast),
        .res_tvalid(res_tvalid), .res_tready(res_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][11:0] val;
        logic [11:0]      thr;
        logic [3:0]       wlen;
        logic [7:0][23:0] sq;
        logic [7:0][7:0]  gt;
        logic [7:0][7:0]  lt;
    } vec_t;

    vec_t vt [6];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_vals(input logic [7:0][11:0] v);
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NSM; s++)
                dat_i[12*(c*NSM+s) +: 12] = v[c];
    endtask

    task automatic do_abort();
        @(negedge clk); abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0;
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!res_tvalid && g < 200) begin
            @(negedge clk); g++;
        end
        chk("tvalid_wait", 64'(res_tvalid), 64'd1);
    endtask

    // stall=1 applies a 1-0-0-1 tready pattern and pokes start_i during RUN.
    task automatic run_vec(input int k, input bit stall);
        int beat, cyc;
        bit stalled;
        logic [39:0] held;
        logic [2:0]  held_u;
        logic [3:0]  pat;
        pat = 4'b1001;
        drive_vals(vt[k].val);
        @(negedge clk);
        wlen_i = vt[k].wlen; thresh_i = vt[k].thr; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_run", 64'(busy_o), 64'd1);
        if (stall) begin
            wlen_i = 4'd1; thresh_i = 12'h000; start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        wait_valid();
        beat = 0; cyc = 0; stalled = 1'b0; held = '0; held_u = '0;
        while (beat < NCH && cyc < 100) begin
            chk("tvalid_hold", 64'(res_tvalid), 64'd1);
            if (stalled) begin
                chk("stall_tdata", 64'(res_tdata), 64'(held));
                chk("stall_tuser", 64'(res_tuser), 64'(held_u));
            end
            res_tready = stall ? pat[3 - (cyc % 4)] : 1'b1;
            #1;
            if (res_tvalid && res_tready) begin
                chk($sformatf("v%0d_tdata_ch%0d", k, beat), 64'(res_tdata),
                    64'({vt[k].lt[beat], vt[k].gt[beat], vt[k].sq[beat]}));
                chk($sformatf("v%0d_tuser", k), 64'(res_tuser), 64'(beat));
                chk($sformatf("v%0d_tlast", k), 64'(res_tlast), 64'(beat == NCH-1));
                chk("done_early", 64'(done_o), 64'd0);
                beat++; stalled = 1'b0;
            end else begin
                stalled = 1'b1; held = res_tdata; held_u = res_tuser;
            end
            cyc++;
            @(negedge clk);
        end
        res_tready = 1'b1;
        chk("beats_seen", 64'(beat), 64'(NCH));
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("tvalid_after", 64'(res_tvalid), 64'd0);
        chk("busy_after", 64'(busy_o), 64'(CONT));
        @(negedge clk);
        chk("done_one_cycle", 64'(done_o), 64'd0);
        if (CONT) do_abort();
    endtask

    initial begin
        // V0: all +16, thr 8, 4 clocks: 256*8*4 = 8192, gt 32
        for (int c = 0; c < NCH; c++) begin
            vt[0].val[c] = 12'h010; vt[0].sq[c] = 24'd8192; vt[0].gt[c] = 8'd32; vt[0].lt[c] = 8'd0;
        end
        vt[0].thr = 12'd8; vt[0].wlen = 4'd4;
        // V1: ch3 = -2048, wlen 0 -> 16 clocks; 2^22*128 saturates 24 bits, lt 128
        for (int c = 0; c < NCH; c++) begin
            vt[1].val[c] = 12'h000; vt[1].sq[c] = 24'd0; vt[1].gt[c] = 8'd0; vt[1].lt[c] = 8'd0;
        end
        vt[1].val[3] = 12'h800; vt[1].sq[3] = 24'hFFFFFF; vt[1].lt[3] = 8'd128;
        vt[1].thr = 12'd2047; vt[1].wlen = 4'd0;
        // V2: all -2048, 8 clocks, thr 0: saturated sq, lt 64
        for (int c = 0; c < NCH; c++) begin
            vt[2].val[c] = 12'h800; vt[2].sq[c] = 24'hFFFFFF; vt[2].gt[c] = 8'd0; vt[2].lt[c] = 8'd64;
        end
        vt[2].thr = 12'd0; vt[2].wlen = 4'd8;
        // V3: thr 0, 1 clock, mixed values {0,1,-1,5,-7,2047,-2048,100}
        vt[3].val = {12'h064, 12'h800, 12'h7FF, 12'hFF9, 12'h005, 12'hFFF, 12'h001, 12'h000};
        vt[3].sq  = {24'd80000, 24'hFFFFFF, 24'hFFFFFF, 24'd392, 24'd200, 24'd8, 24'd8, 24'd0};
        vt[3].gt  = {8'd8, 8'd0, 8'd8, 8'd0, 8'd8, 8'd0, 8'd8, 8'd0};
        vt[3].lt  = {8'd0, 8'd8, 8'd0, 8'd8, 8'd0, 8'd8, 8'd0, 8'd0};
        vt[3].thr = 12'd0; vt[3].wlen = 4'd1;
        // V4: thr 5, 2 clocks, {5,-5,6,-6,-2048,2047,0,4}: +-5 at threshold count nowhere
        vt[4].val = {12'h004, 12'h000, 12'h7FF, 12'h800, 12'hFFA, 12'h006, 12'hFFB, 12'h005};
        vt[4].sq  = {24'd256, 24'd0, 24'hFFFFFF, 24'hFFFFFF, 24'd576, 24'd576, 24'd400, 24'd400};
        vt[4].gt  = {8'd0, 8'd0, 8'd16, 8'd0, 8'd0, 8'd16, 8'd0, 8'd0};
        vt[4].lt  = {8'd0, 8'd0, 8'd0, 8'd16, 8'd16, 8'd0, 8'd0, 8'd0};
        vt[4].thr = 12'd5; vt[4].wlen = 4'd2;
        // V5: thr 2048, 3 clocks: nothing can exceed it in either direction
        vt[5].val = {12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h001, 12'h7FF, 12'h800};
        vt[5].sq  = {24'd0, 24'd0, 24'd0, 24'd0, 24'd24, 24'd24, 24'hFFFFFF, 24'hFFFFFF};
        vt[5].gt  = '0;
        vt[5].lt  = '0;
        vt[5].thr = 12'h800; vt[5].wlen = 4'd3;

        aresetn = 1'b0; start_i = 1'b0; abort_i = 1'b0; res_tready = 1'b1;
        wlen_i = '0; thresh_i = '0; dat_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_tvalid", 64'(res_tvalid), 64'd0);
        chk("rst_tlast", 64'(res_tlast), 64'd0);
        chk("rst_tdata", 64'(res_tdata), 64'd0);
        chk("rst_tuser", 64'(res_tuser), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(k, 1'b0);

        run_vec(0, 1'b1);

        // Abort at RUN cycle 2
        drive_vals(vt[4].val);
        wlen_i = vt[4].wlen; thresh_i = vt[4].thr;
        wlen_i = 4'd6; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0;
        chk("abort_run_busy", 64'(busy_o), 64'd0);
        chk("abort_run_tvalid", 64'(res_tvalid), 64'd0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_run_nodone", 64'(done_o | res_tvalid), 64'd0);
            @(negedge clk);
        end

        // Abort during DUMP after three accepted beats
        drive_vals(vt[0].val);
        wlen_i = vt[0].wlen; thresh_i = vt[0].thr; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_valid();
        repeat (3) @(negedge clk);
        chk("abort_dump_beat", 64'(res_tuser), 64'd3);
        res_tready = 1'b0; abort_i = 1'b1;
        @(negedge clk); abort_i = 1'b0; res_tready = 1'b1;
        chk("abort_dump_tvalid", 64'(res_tvalid), 64'd0);
        chk("abort_dump_busy", 64'(busy_o), 64'd0);
        chk("abort_dump_done", 64'(done_o), 64'd0);
        @(negedge clk);
        chk("abort_dump_done2", 64'(done_o), 64'd0);

        run_vec(3, 1'b0);

`ifdef AGC_MULTI_STATS_CONTINUOUS_EN
        // Continuous: +1 everywhere, thr 0, 2 clocks -> sq 16, gt 16 on every repeated dump
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NSM; s++)
                dat_i[12*(c*NSM+s) +: 12] = 12'h001;
        @(negedge clk);
        wlen_i = 4'd2; thresh_i = 12'd0; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_valid();
            for (int b = 0; b < NCH; b++) begin
                chk("cont_tdata", 64'(res_tdata), 64'({8'd0, 8'd16, 24'd16}));
                chk("cont_tuser", 64'(res_tuser), 64'(b));
                chk("cont_busy", 64'(busy_o), 64'd1);
                @(negedge clk);
            end
            chk("cont_done", 64'(done_o), 64'd1);
            chk("cont_busy_done", 64'(busy_o), 64'd1);
        end
        do_abort();
        chk("cont_abort_busy", 64'(busy_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
